// File: rtl/fft_alert_gen.sv
// rtl/fft_alert_gen.sv - modulo-10 sample sequencer with per-stage staggered alert pulses
// Counts accepted samples, pulses an alert every tenth, and fans it out to each FFT stage.
module fft_alert_gen #(
  parameter int NUM_STAGES = 4,
  parameter int STAGE_DLY  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  din_valid_i,
  output logic [NUM_STAGES-1:0] alert_mod10_o,
  output logic [3:0]            cnt_mod10_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int SR_LEN    = (NUM_STAGES - 1) * STAGE_DLY;
  localparam int FLUSH_CYC = SR_LEN + 4;
  localparam int FCW       = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           base_q, base_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fc_q    <= '0;
      base_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      base_q  <= base_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    base_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        fc_d  = '0;
        if (start_i) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A sample arriving with stop is still counted and may raise the last alert.
        if (din_valid_i) begin
          if (cnt_q == 4'd9) begin
            cnt_d  = '0;
            base_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        if (stop_i) begin
          state_d = S_FLUSH;
          fc_d    = FCW'(FLUSH_CYC);
        end
      end
      S_FLUSH: begin
        if (fc_q <= FCW'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          fc_d    = '0;
          done_d  = 1'b1;
        end else begin
          fc_d = fc_q - FCW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        fc_d    = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign alert_mod10_o[0] = base_q;
  assign cnt_mod10_o      = cnt_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

  generate
    if (SR_LEN > 0) begin : g_stagger
      logic [SR_LEN-1:0] sr_q;

      // Shifts every cycle regardless of state so in-flight alerts drain during flush.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          sr_q <= '0;
        end else begin
          sr_q[0] <= base_q;
          for (int i = 1; i < SR_LEN; i++) begin
            sr_q[i] <= sr_q[i-1];
          end
        end
      end

      for (genvar k = 1; k < NUM_STAGES; k++) begin : g_tap
        assign alert_mod10_o[k] = sr_q[k*STAGE_DLY-1];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fft_alert_gen.sv
// tb/tb_fft_alert_gen.sv - scoreboard bench for fft_alert_gen, default and single-stage configs
// Both instances share stimulus; a cycle-level event model predicts their outputs.
module tb_fft_alert_gen;

  localparam int NS_A = 4;
  localparam int SD_A = 2;
  localparam int NS_B = 1;
  localparam int SD_B = 1;

  logic       clk;
  logic       rstn;
  logic       start_i;
  logic       stop_i;
  logic       din_valid_i;
  logic [3:0] alert_a;
  logic [0:0] alert_b;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;
  logic       busy_a;
  logic       busy_b;
  logic       done_a;
  logic       done_b;

  fft_alert_gen #(.NUM_STAGES(NS_A), .STAGE_DLY(SD_A)) dut_a (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .din_valid_i  (din_valid_i),
    .alert_mod10_o(alert_a),
    .cnt_mod10_o  (cnt_a),
    .busy_o       (busy_a),
    .done_o       (done_a)
  );

  fft_alert_gen #(.NUM_STAGES(NS_B), .STAGE_DLY(SD_B)) dut_b (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .din_valid_i  (din_valid_i),
    .alert_mod10_o(alert_b),
    .cnt_mod10_o  (cnt_b),
    .busy_o       (busy_b),
    .done_o       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] a4;
    logic       a1;
    logic [3:0] c4;
    logic [3:0] c1;
    logic       b4;
    logic       b1;
    logic       d4;
    logic       d1;
  } obs_t;

  obs_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: run mode per config (0 idle, 1 run, 2 flush), count, flush end edge, alert calendar.
  int       n = 0;
  int       mode_m[2];
  int       cnt_m[2];
  int       fend_m[2];
  bit       done_m[2];
  bit [3:0] sched[int];

  function automatic int ns_of(input int c);
    return (c == 0) ? NS_A : NS_B;
  endfunction

  function automatic int sd_of(input int c);
    return (c == 0) ? SD_A : SD_B;
  endfunction

  function automatic bit [3:0] sched_at(input int key);
    return sched.exists(key) ? sched[key] : 4'b0;
  endfunction

  task automatic model_reset();
    sched.delete();
    for (int c = 0; c < 2; c++) begin
      mode_m[c] = 0;
      cnt_m[c]  = 0;
      fend_m[c] = 0;
      done_m[c] = 1'b0;
    end
  endtask

  task automatic push_zero();
    sbq.push_back('0);
  endtask

  task automatic model_edge(input logic st, input logic sp, input logic dv);
    obs_t e;
    n++;
    for (int c = 0; c < 2; c++) begin
      done_m[c] = 1'b0;
      case (mode_m[c])
        0: if (st) begin
          mode_m[c] = 1;
          cnt_m[c]  = 0;
        end
        1: begin
          if (dv) begin
            if (cnt_m[c] == 9) begin
              for (int k = 0; k < ns_of(c); k++) begin
                int key;
                key = c * 1000000 + n + k * sd_of(c);
                sched[key] = sched_at(key) | 4'(1 << k);
              end
            end
            cnt_m[c] = (cnt_m[c] + 1) % 10;
          end
          if (sp) begin
            mode_m[c] = 2;
            fend_m[c] = n + (ns_of(c) - 1) * sd_of(c) + 4;
          end
        end
        default: if (n == fend_m[c]) begin
          mode_m[c] = 0;
          cnt_m[c]  = 0;
          done_m[c] = 1'b1;
        end
      endcase
    end
    e.a4 = sched_at(n);
    e.a1 = sched_at(1000000 + n) != 4'b0;
    e.c4 = 4'(cnt_m[0]);
    e.c1 = 4'(cnt_m[1]);
    e.b4 = mode_m[0] != 0;
    e.b1 = mode_m[1] != 0;
    e.d4 = done_m[0];
    e.d1 = done_m[1];
    sbq.push_back(e);
  endtask

  task automatic step(input logic st, input logic sp, input logic dv);
    start_i     = st;
    stop_i      = sp;
    din_valid_i = dv;
    @(posedge clk);
    model_edge(st, sp, dv);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rstn        = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    din_valid_i = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({alert_a, alert_b, cnt_a, cnt_b, busy_a, busy_b, done_a, done_b} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: outputs a=%b/%b cnt=%0d/%0d busy=%b/%b done=%b/%b, required all 0",
               alert_a, alert_b, cnt_a, cnt_b, busy_a, busy_b, done_a, done_b);
    end
    repeat (2) begin
      @(posedge clk);
      push_zero();
      #1;
    end
    rstn = 1'b1;
  endtask

  obs_t mon_exp;
  obs_t mon_got;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_exp = sbq.pop_front();
      mon_got = {alert_a, alert_b[0], cnt_a, cnt_b, busy_a, busy_b, done_a, done_b};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard t=%0t: actual alert=%b/%b cnt=%0d/%0d busy=%b/%b done=%b/%b required alert=%b/%b cnt=%0d/%0d busy=%b/%b done=%b/%b",
                 $time, mon_got.a4, mon_got.a1, mon_got.c4, mon_got.c1, mon_got.b4, mon_got.b1,
                 mon_got.d4, mon_got.d1, mon_exp.a4, mon_exp.a1, mon_exp.c4, mon_exp.c1,
                 mon_exp.b4, mon_exp.b1, mon_exp.d4, mon_exp.d1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    start_i     = 1'b0;
    stop_i      = 1'b0;
    din_valid_i = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      push_zero();
    end
    #1;
    rstn = 1'b1;

    // 25 back-to-back samples, then stop and drain.
    step(1, 0, 0);
    for (int i = 0; i < 25; i++) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    repeat (14) step(0, 0, 0);

    // Gapped samples: one valid every third cycle.
    step(1, 0, 0);
    for (int i = 0; i < 30; i++) step(0, 0, (i % 3) == 2);
    repeat (8) step(0, 0, 0);
    step(0, 1, 0);
    repeat (14) step(0, 0, 0);

    // Stop together with the tenth sample; start and din_valid pressed during flush.
    step(1, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    step(0, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 1);
    repeat (6) step(0, 0, 1);

    // din_valid in idle, then start and stop together in idle.
    repeat (5) step(0, 0, 1);
    step(1, 1, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    repeat (3) step(0, 0, 0);

    // Reset three cycles after a base alert discards the staggered copies.
    apply_reset();
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    apply_reset();
    repeat (10) step(0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75);
      end
    end
    repeat (16) step(0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected observations left unchecked, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
